// File: rtl/mp_irq_pulse_gen.sv
// Interrupt output stage: merges user-event rising edges and retry pulses into
// fixed-width IRQ pulses separated by a hold-off, coalescing requests that
// arrive while the line is busy into a single pending request.
module mp_irq_pulse_gen #(
   parameter int unsigned IRQ_PULSE_WIDTH = 16,
   parameter int unsigned IRQ_HOLDOFF     = 64,
   parameter int unsigned COUNT_WIDTH     = 32
) (
   input  logic                   CLK,
   input  logic                   RESET,
   input  logic                   USER_EVENT_IN,
   input  logic                   RETRY,
   output logic                   IRQ,
   output logic                   IRQ_PENDING,
   output logic [COUNT_WIDTH-1:0] IRQ_COUNT,
   output logic [COUNT_WIDTH-1:0] COALESCED_COUNT
);

   // One timer shared by ASSERT and HOLDOFF; sized for the longer of the two.
   localparam int unsigned MaxCnt = (IRQ_PULSE_WIDTH > IRQ_HOLDOFF) ? IRQ_PULSE_WIDTH
                                                                   : IRQ_HOLDOFF;
   localparam int unsigned TimerW = (MaxCnt > 1) ? $clog2(MaxCnt) : 1;
   localparam logic [TimerW-1:0] WLoad = TimerW'(IRQ_PULSE_WIDTH - 1);
   localparam logic [TimerW-1:0] HLoad = TimerW'(IRQ_HOLDOFF - 1);

   typedef enum logic [1:0] {StIdle, StAssert, StHoldoff} state_e;

   state_e                 state_q, state_d;
   logic [TimerW-1:0]      timer_q, timer_d;
   logic                   d_event_q, d_event_d;
   logic                   irq_q, irq_d;
   logic                   pending_q, pending_d;
   logic [COUNT_WIDTH-1:0] irq_cnt_q, irq_cnt_d;
   logic [COUNT_WIDTH-1:0] coal_cnt_q, coal_cnt_d;

   logic       edge_det;
   logic       req;
   logic       timer_last;
   logic       absorb;
   logic [1:0] coal_inc;

   // Next-state logic: request detection, FSM sequencing, pending and counters.
   always_comb begin
      edge_det   = USER_EVENT_IN & ~d_event_q;
      req        = edge_det | RETRY;
      timer_last = (timer_q == '0);
      d_event_d  = USER_EVENT_IN;
      state_d    = state_q;
      timer_d    = timer_q;
      pending_d  = pending_q;
      irq_cnt_d  = irq_cnt_q;
      absorb     = 1'b0;
      coal_inc   = 2'd0;

      case (state_q)
         StIdle: begin
            if (req || pending_q) begin
               state_d = StAssert;
               timer_d = WLoad;
            end
         end
         StAssert: begin
            absorb = req;
            if (timer_last) begin
               state_d = StHoldoff;
               timer_d = HLoad;
            end else begin
               timer_d = timer_q - TimerW'(1);
            end
         end
         StHoldoff: begin
            if (timer_last) begin
               // A request on the last hold-off cycle launches directly, not via pending.
               if (req || pending_q) begin
                  state_d = StAssert;
                  timer_d = WLoad;
               end else begin
                  state_d = StIdle;
               end
            end else begin
               absorb  = req;
               timer_d = timer_q - TimerW'(1);
            end
         end
         default: begin
            state_d = StIdle;
            timer_d = '0;
         end
      endcase

      if (absorb) begin
         if (!pending_q) begin
            pending_d = 1'b1;
         end else begin
            coal_inc = coal_inc + 2'd1;
         end
      end

      // Simultaneous edge and retry collapse into one request; count the merge.
      if (edge_det && RETRY) begin
         coal_inc = coal_inc + 2'd1;
      end

      if ((state_d == StAssert) && (state_q != StAssert)) begin
         pending_d = 1'b0;
         irq_cnt_d = irq_cnt_q + COUNT_WIDTH'(1);
      end

      coal_cnt_d = coal_cnt_q + COUNT_WIDTH'(coal_inc);
      irq_d      = (state_d == StAssert);
   end

   // State and registered outputs; async reset clears everything immediately.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_q    <= StIdle;
         timer_q    <= '0;
         d_event_q  <= 1'b0;
         irq_q      <= 1'b0;
         pending_q  <= 1'b0;
         irq_cnt_q  <= '0;
         coal_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         timer_q    <= timer_d;
         d_event_q  <= d_event_d;
         irq_q      <= irq_d;
         pending_q  <= pending_d;
         irq_cnt_q  <= irq_cnt_d;
         coal_cnt_q <= coal_cnt_d;
      end
   end

   assign IRQ             = irq_q;
   assign IRQ_PENDING     = pending_q;
   assign IRQ_COUNT       = irq_cnt_q;
   assign COALESCED_COUNT = coal_cnt_q;

endmodule

// File: tb/tb_mp_irq_pulse_gen.sv
// Directed bench for mp_irq_pulse_gen with W=4, H=3 and 3-bit counters.
module tb_mp_irq_pulse_gen;

   localparam int unsigned W  = 4;
   localparam int unsigned H  = 3;
   localparam int unsigned CW = 3;

   logic          clk;
   logic          rst;
   logic          ev;
   logic          rt;
   logic          irq;
   logic          pend;
   logic [CW-1:0] irq_cnt;
   logic [CW-1:0] coal_cnt;

   int tests;
   int fails;
   int rises;
   logic prev_irq;

   mp_irq_pulse_gen #(
      .IRQ_PULSE_WIDTH(W),
      .IRQ_HOLDOFF    (H),
      .COUNT_WIDTH    (CW)
   ) dut (
      .CLK            (clk),
      .RESET          (rst),
      .USER_EVENT_IN  (ev),
      .RETRY          (rt),
      .IRQ            (irq),
      .IRQ_PENDING    (pend),
      .IRQ_COUNT      (irq_cnt),
      .COALESCED_COUNT(coal_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic e, input logic r);
      ev = e;
      rt = r;
   endtask

   // Advance one clock and sample 1 time unit after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
      if (irq && !prev_irq) rises++;
      prev_irq = irq;
   endtask

   task automatic do_reset();
      drive(1'b0, 1'b0);
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst      = 1'b0;
      rises    = 0;
      prev_irq = 1'b0;
   endtask

   logic [14:0] exp_a;

   initial begin
      tests    = 0;
      fails    = 0;
      rises    = 0;
      prev_irq = 1'b0;
      ev       = 1'b0;
      rt       = 1'b0;
      rst      = 1'b1;
      #1;
      check("rst_irq", 32'(irq), 32'd0);
      check("rst_pend", 32'(pend), 32'd0);
      check("rst_cnt", 32'(irq_cnt), 32'd0);
      check("rst_coal", 32'(coal_cnt), 32'd0);

      // Edge at cycle N, RETRY at N+2 during the pulse -> second pulse at N+8.
      do_reset();
      repeat (3) tick();
      exp_a = 15'b000011110001111;
      for (int i = 0; i < 15; i++) begin
         drive(1'b1, (i == 2));
         tick();
         check("a_irq", 32'(irq), 32'(exp_a[i]));
         check("a_pend", 32'(pend), 32'((i >= 2) && (i <= 6)));
         if (i == 0) check("a_cnt1", 32'(irq_cnt), 32'd1);
         if (i == 7) check("a_cnt2", 32'(irq_cnt), 32'd2);
      end
      check("a_rises", 32'(rises), 32'd2);
      check("a_coal", 32'(coal_cnt), 32'd0);

      // Three requests during one pulse -> one extra pulse, two coalesced.
      do_reset();
      drive(1'b0, 1'b1); tick();
      check("b_irq", 32'(irq), 32'd1);
      drive(1'b1, 1'b0); tick();
      check("b_pend", 32'(pend), 32'd1);
      drive(1'b1, 1'b1); tick();
      drive(1'b1, 1'b1); tick();
      check("b_coal_mid", 32'(coal_cnt), 32'd2);
      drive(1'b0, 1'b0);
      repeat (20) tick();
      check("b_rises", 32'(rises), 32'd2);
      check("b_cnt", 32'(irq_cnt), 32'd2);
      check("b_coal", 32'(coal_cnt), 32'd2);

      // Edge and RETRY in the same idle cycle.
      do_reset();
      drive(1'b1, 1'b1); tick();
      check("c_irq", 32'(irq), 32'd1);
      check("c_coal1", 32'(coal_cnt), 32'd1);
      drive(1'b0, 1'b0);
      repeat (15) tick();
      check("c_rises", 32'(rises), 32'd1);
      check("c_cnt", 32'(irq_cnt), 32'd1);
      check("c_coal", 32'(coal_cnt), 32'd1);
      check("c_pend", 32'(pend), 32'd0);

      // Level held high for 100 cycles -> one pulse.
      do_reset();
      drive(1'b1, 1'b0);
      repeat (100) tick();
      check("d_rises", 32'(rises), 32'd1);
      check("d_cnt", 32'(irq_cnt), 32'd1);
      drive(1'b0, 1'b0);

      // Async reset in the 2nd pulse cycle with a pending request.
      do_reset();
      drive(1'b0, 1'b1); tick();
      drive(1'b0, 1'b1); tick();
      check("e_pend_pre", 32'(pend), 32'd1);
      check("e_irq_pre", 32'(irq), 32'd1);
      drive(1'b0, 1'b0);
      #2 rst = 1'b1;
      #1;
      check("e_irq", 32'(irq), 32'd0);
      check("e_pend", 32'(pend), 32'd0);
      check("e_cnt", 32'(irq_cnt), 32'd0);
      check("e_coal", 32'(coal_cnt), 32'd0);
      #1 rst = 1'b0;
      rises    = 0;
      prev_irq = 1'b0;
      repeat (20) tick();
      check("e_rises", 32'(rises), 32'd0);

      // Same, but USER_EVENT_IN is high when reset releases.
      do_reset();
      drive(1'b0, 1'b1); tick();
      drive(1'b0, 1'b1); tick();
      drive(1'b0, 1'b0);
      #2 rst = 1'b1;
      #1;
      check("f_irq", 32'(irq), 32'd0);
      check("f_pend", 32'(pend), 32'd0);
      ev = 1'b1;
      #1 rst = 1'b0;
      rises    = 0;
      prev_irq = 1'b0;
      #1;
      check("f_irq_prerel", 32'(irq), 32'd0);
      tick();
      check("f_irq_first", 32'(irq), 32'd1);
      repeat (W - 1) tick();
      check("f_irq_last", 32'(irq), 32'd1);
      tick();
      check("f_irq_end", 32'(irq), 32'd0);
      repeat (20) tick();
      check("f_rises", 32'(rises), 32'd1);
      check("f_cnt", 32'(irq_cnt), 32'd1);
      drive(1'b0, 1'b0);

      // IRQ_COUNT wraps from all-ones to zero.
      do_reset();
      for (int p = 1; p <= 9; p++) begin
         drive(1'b0, 1'b1); tick();
         drive(1'b0, 1'b0);
         repeat (W + H - 1) tick();
         if (p == 7) check("w_cnt7", 32'(irq_cnt), 32'd7);
         if (p == 8) check("w_cnt8", 32'(irq_cnt), 32'd0);
      end
      check("w_cnt9", 32'(irq_cnt), 32'd1);
      check("w_rises", 32'(rises), 32'd9);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
